// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780 read transaction engine (busy flag or data RAM) with optional busy polling.
module lcd_reader #(
  parameter int CYCLES_PER_US = 50,
  parameter int SETUP_CYC     = 4,
  parameter int E_HIGH_CYC    = 50,
  parameter int E_LOW_CYC     = 50,
  parameter int TIMEOUT_US    = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  input  logic [3:0] lcd_data_i,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       bus_own
);
  localparam int M0 = CYCLES_PER_US > SETUP_CYC ? CYCLES_PER_US : SETUP_CYC;
  localparam int M1 = M0 > E_HIGH_CYC ? M0 : E_HIGH_CYC;
  localparam int M2 = M1 > E_LOW_CYC ? M1 : E_LOW_CYC;
  localparam int MX = M2 > TIMEOUT_US ? M2 : TIMEOUT_US;
  localparam int CW = $clog2(MX) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, EH1, EL1, EH2, EL2, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q, pre_q, us_q, lim;
  logic [3:0]      sync1_q, sync2_q, hi_q, lo_q;
  logic            poll_q, lcd_e_q, lcd_rs_q, lcd_rw_q, bus_own_q;
  logic            rsp_valid_q, rsp_timeout_q;
  logic [7:0]      rsp_data_q;
  logic            last, pre_last, expired;
  always_comb begin
    lim = (state_q == SETUP) ? CW'(SETUP_CYC - 1) :
          (state_q == EH1 || state_q == EH2) ? CW'(E_HIGH_CYC - 1) : CW'(E_LOW_CYC - 1);
  end
  assign last        = cnt_q == lim;
  assign pre_last    = pre_q == CW'(CYCLES_PER_US - 1);
  assign expired     = us_q == CW'(TIMEOUT_US);
  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign lcd_e       = lcd_e_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_rw      = lcd_rw_q;
  assign bus_own     = bus_own_q;
  // Control outputs are registered on state entry so they line up exactly with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pre_q         <= '0;
      us_q          <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      poll_q        <= 1'b0;
      lcd_e_q       <= 1'b0;
      lcd_rs_q      <= 1'b0;
      lcd_rw_q      <= 1'b0;
      bus_own_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= 8'h00;
    end else begin
      sync1_q       <= lcd_data_i;
      sync2_q       <= sync1_q;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      pre_q         <= (state_q == IDLE || pre_last) ? '0 : pre_q + 1'b1;
      if (state_q == IDLE)
        us_q <= '0;
      else if (pre_last && !expired)
        us_q <= us_q + 1'b1;
      if (state_q != IDLE && state_q != DONE)
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        IDLE: if (cmd_valid) begin
          state_q   <= SETUP;
          cnt_q     <= '0;
          poll_q    <= cmd_poll && !cmd_rs;
          bus_own_q <= 1'b1;
          lcd_rw_q  <= 1'b1;
          lcd_rs_q  <= cmd_rs;
        end
        SETUP: if (last) begin
          state_q <= EH1;
          lcd_e_q <= 1'b1;
        end
        EH1: if (last) begin
          state_q <= EL1;
          hi_q    <= sync2_q;
          lcd_e_q <= 1'b0;
        end
        EL1: if (last) begin
          state_q <= EH2;
          lcd_e_q <= 1'b1;
        end
        EH2: if (last) begin
          state_q <= EL2;
          lo_q    <= sync2_q;
          lcd_e_q <= 1'b0;
        end
        EL2: if (last) begin
          if (poll_q && hi_q[3] && !expired) begin
            state_q <= EH1;
            lcd_e_q <= 1'b1;
          end else begin
            state_q   <= DONE;
            bus_own_q <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_rs_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q       <= IDLE;
          rsp_valid_q   <= 1'b1;
          rsp_data_q    <= {hi_q, lo_q};
          rsp_timeout_q <= poll_q && hi_q[3] && expired;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed steps with a response scoreboard and an LCD nibble model.
module tb_lcd_reader;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_valid1, cmd_rs, cmd_poll;
  logic [3:0] lcd_data;
  logic       cmd_ready, rsp_valid, rsp_timeout, lcd_e, lcd_rs, lcd_rw, bus_own;
  logic [7:0] rsp_data;
  logic       rdy1, v1, to1, e1, rs1, rw1, own1;
  logic [7:0] d1;
  logic       sel, e_sel;
  int         checks = 0, passes = 0, prot_err = 0, rises = 0;
  logic [3:0] nq[$];
  typedef struct {logic [7:0] d; logic to; int lat;} exp_t;
  exp_t sb[$];

  lcd_reader u_dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_poll(cmd_poll), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .lcd_data_i(lcd_data), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .bus_own(bus_own));
  lcd_reader #(.TIMEOUT_US(10)) u_to (.clk(clk), .rst(rst), .cmd_valid(cmd_valid1),
    .cmd_ready(rdy1), .cmd_rs(cmd_rs), .cmd_poll(cmd_poll), .rsp_valid(v1), .rsp_data(d1),
    .rsp_timeout(to1), .lcd_data_i(lcd_data), .lcd_e(e1), .lcd_rs(rs1), .lcd_rw(rw1),
    .bus_own(own1));

  always #5 clk = ~clk;
  assign e_sel = sel ? e1 : lcd_e;

  always @(posedge e_sel) begin
    rises++;
    if (nq.size() > 0) lcd_data = nq.pop_front();
  end

  logic pe = 1'b0, prs = 1'b0, prw = 1'b0;
  always @(negedge clk) begin
    if (lcd_e && !lcd_rw) prot_err++;
    if (e1 && !rw1) prot_err++;
    if (lcd_e && pe && (lcd_rs !== prs || lcd_rw !== prw)) prot_err++;
    if (rsp_timeout && !rsp_valid) prot_err++;
    if (to1 && !v1) prot_err++;
    pe = lcd_e; prs = lcd_rs; prw = lcd_rw;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input bit which);
    int n = 0;
    if (which) cmd_valid1 = 1'b1; else cmd_valid = 1'b1;
    while (!(which ? rdy1 : cmd_ready) && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("accept_wait", n < 1000, 1);
  endtask

  task automatic await_rsp(input bit which, input logic exp_rs);
    int n = 0, bad = 0;
    exp_t e;
    while (n < 2000) begin
      @(posedge clk); #1; n++;
      if (which ? v1 : rsp_valid) break;
      if (!which) begin
        if (cmd_ready) bad++;
        if (bus_own && (lcd_rs !== exp_rs || lcd_rw !== 1'b1)) bad++;
      end
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("rsp_data", which ? d1 : rsp_data, e.d);
    chk("rsp_timeout", which ? to1 : rsp_timeout, e.to);
    chk("busy_ctl", bad, 0);
  endtask

  initial begin
    int base, n, cnt;
    rst = 1; cmd_valid = 0; cmd_valid1 = 0; cmd_rs = 0; cmd_poll = 0; lcd_data = 0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {lcd_e, lcd_rs, lcd_rw, bus_own, own1}, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_data}, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 0; #1;
    chk("ready_idle", cmd_ready, 1);

    // data read
    nq = '{4'hA, 4'h5}; sb.push_back('{8'hA5, 1'b0, 205});
    cmd_rs = 1; cmd_poll = 0; base = rises;
    accept(0); cmd_valid = 0;
    await_rsp(0, 1);
    chk("data_rises", rises - base, 2);

    // busy poll: three BF=1 reads then ready
    nq = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h3}; sb.push_back('{8'h03, 1'b0, 805});
    cmd_rs = 0; cmd_poll = 1; base = rises;
    accept(0); cmd_valid = 0;
    await_rsp(0, 0);
    chk("poll_rises", rises - base, 8);

    // poll timeout on the TIMEOUT_US=10 instance
    sel = 1; nq.delete(); lcd_data = 4'hF; sb.push_back('{8'hFF, 1'b1, 605});
    accept(1); cmd_valid1 = 0;
    await_rsp(1, 0);
    sel = 0;

    // poll ignored for data reads
    nq = '{4'h8, 4'h0}; sb.push_back('{8'h80, 1'b0, 205});
    cmd_rs = 1; cmd_poll = 1; base = rises;
    accept(0); cmd_valid = 0;
    await_rsp(0, 1);
    chk("rspoll_rises", rises - base, 2);

    // reset during EH2
    nq = '{4'hA, 4'h5}; cmd_poll = 0; base = rises;
    accept(0); cmd_valid = 0;
    n = 0;
    while (rises < base + 2 && n < 500) begin @(posedge clk); #1; n++; end
    chk("reach_eh2", n < 500, 1);
    repeat (10) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1;
    chk("midrst_ctl", {lcd_e, lcd_rw, bus_own, rsp_valid}, 0);
    rst = 0; #1;
    chk("midrst_ready", cmd_ready, 1);
    cnt = 0;
    repeat (300) begin @(posedge clk); #1; if (rsp_valid) cnt++; end
    chk("midrst_norsp", cnt, 0);
    nq = '{4'h3, 4'hC}; sb.push_back('{8'h3C, 1'b0, 205});
    accept(0); cmd_valid = 0;
    await_rsp(0, 1);

    // back-to-back with cmd_valid held
    nq = '{4'h1, 4'h2, 4'h4, 4'h8};
    sb.push_back('{8'h12, 1'b0, 205}); sb.push_back('{8'h48, 1'b0, 205});
    accept(0);
    await_rsp(0, 1);
    @(posedge clk); #1;
    chk("b2b_accept", {cmd_ready, bus_own}, 2'b01);
    cmd_valid = 0;
    await_rsp(0, 1);

    chk("protocol", prot_err, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
